// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand sequencer: state encodings,
// special-value class bit positions and the packed operand width.
package fpu_pkg;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    UNPACK = 2'd2,
    PUT    = 2'd3
  } seq_state_e;

  localparam int CLS_ZERO   = 0;
  localparam int CLS_DENORM = 1;
  localparam int CLS_INF    = 2;
  localparam int CLS_NAN    = 3;

  localparam logic [3:0] ZERO_CLASS = 4'b0001 << CLS_ZERO;

  function automatic int op_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fpu_operand_sequencer_if.sv
// Operand input stream and unpacked-pair output stream of the sequencer.
interface fpu_operand_sequencer_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);

  logic [op_width(EXP_W, MAN_W)-1:0] in_data;
  logic                              in_valid;
  logic                              in_unary;
  logic                              in_ready;
  logic                              out_valid;
  logic                              out_ready;
  logic                              a_sign;
  logic                              b_sign;
  logic [EXP_W-1:0]                  a_exp;
  logic [EXP_W-1:0]                  b_exp;
  logic [MAN_W:0]                    a_man;
  logic [MAN_W:0]                    b_man;
  logic [3:0]                        a_class;
  logic [3:0]                        b_class;
  logic                              unary_out;

  modport slave (
    input  in_data, in_valid, in_unary, out_ready,
    output in_ready, out_valid, a_sign, b_sign, a_exp, b_exp,
           a_man, b_man, a_class, b_class, unary_out
  );

  modport master (
    output in_data, in_valid, in_unary, out_ready,
    input  in_ready, out_valid, a_sign, b_sign, a_exp, b_exp,
           a_man, b_man, a_class, b_class, unary_out
  );

endinterface

// File: rtl/fpu_unpack.sv
// Combinational split of a packed {sign, exp, man} operand into fields,
// restoring the hidden bit and classifying special values.
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [op_width(EXP_W, MAN_W)-1:0] op_i,
  output logic                              sign_o,
  output logic [EXP_W-1:0]                  exp_o,
  output logic [MAN_W:0]                    man_o,
  output logic [3:0]                        class_o
);

  localparam int W = op_width(EXP_W, MAN_W);

  logic [EXP_W-1:0] expField;
  logic [MAN_W-1:0] manField;

  assign expField = op_i[W-2 -: EXP_W];
  assign manField = op_i[MAN_W-1:0];

  // Denormals report exponent 1 so downstream alignment treats them like the
  // smallest normal exponent with a cleared hidden bit.
  always_comb begin
    sign_o  = op_i[W-1];
    exp_o   = expField;
    man_o   = {1'b1, manField};
    class_o = '0;
    if (expField == '0) begin
      if (manField == '0) begin
        exp_o             = '0;
        man_o             = '0;
        class_o[CLS_ZERO] = 1'b1;
      end else begin
        exp_o               = {{(EXP_W-1){1'b0}}, 1'b1};
        man_o               = {1'b0, manField};
        class_o[CLS_DENORM] = 1'b1;
      end
    end else if (&expField) begin
      if (manField == '0) begin
        class_o[CLS_INF] = 1'b1;
      end else begin
        class_o[CLS_NAN] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_operand_sequencer.sv
// Captures operand A then (unless unary) operand B, unpacks both in one
// cycle and holds the pair on the output stream until downstream accepts.
module fpu_operand_sequencer
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  fpu_operand_sequencer_if.slave  bus,
  output logic [1:0]              state_o
);

  localparam int W = op_width(EXP_W, MAN_W);

  seq_state_e       state_q;
  logic [W-1:0]     rawA_q;
  logic [W-1:0]     rawB_q;
  logic             unary_q;

  logic             aSign_q;
  logic             bSign_q;
  logic [EXP_W-1:0] aExp_q;
  logic [EXP_W-1:0] bExp_q;
  logic [MAN_W:0]   aMan_q;
  logic [MAN_W:0]   bMan_q;
  logic [3:0]       aClass_q;
  logic [3:0]       bClass_q;
  logic             unaryOut_q;

  logic             aSign;
  logic             bSign;
  logic [EXP_W-1:0] aExp;
  logic [EXP_W-1:0] bExp;
  logic [MAN_W:0]   aMan;
  logic [MAN_W:0]   bMan;
  logic [3:0]       aClass;
  logic [3:0]       bClass;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) unpackA (
    .op_i    (rawA_q),
    .sign_o  (aSign),
    .exp_o   (aExp),
    .man_o   (aMan),
    .class_o (aClass)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) unpackB (
    .op_i    (rawB_q),
    .sign_o  (bSign),
    .exp_o   (bExp),
    .man_o   (bMan),
    .class_o (bClass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GET_A;
      rawA_q     <= '0;
      rawB_q     <= '0;
      unary_q    <= 1'b0;
      aSign_q    <= 1'b0;
      bSign_q    <= 1'b0;
      aExp_q     <= '0;
      bExp_q     <= '0;
      aMan_q     <= '0;
      bMan_q     <= '0;
      aClass_q   <= '0;
      bClass_q   <= '0;
      unaryOut_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (bus.in_valid) begin
            rawA_q  <= bus.in_data;
            unary_q <= bus.in_unary;
            state_q <= bus.in_unary ? UNPACK : GET_B;
          end
        end
        GET_B: begin
          if (bus.in_valid) begin
            rawB_q  <= bus.in_data;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          aSign_q    <= aSign;
          aExp_q     <= aExp;
          aMan_q     <= aMan;
          aClass_q   <= aClass;
          // A unary pair presents B as a positive zero regardless of stale rawB.
          bSign_q    <= unary_q ? 1'b0 : bSign;
          bExp_q     <= unary_q ? '0 : bExp;
          bMan_q     <= unary_q ? '0 : bMan;
          bClass_q   <= unary_q ? ZERO_CLASS : bClass;
          unaryOut_q <= unary_q;
          state_q    <= PUT;
        end
        PUT: begin
          if (bus.out_ready) begin
            state_q <= GET_A;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == GET_A) || (state_q == GET_B);
  assign bus.out_valid = (state_q == PUT);
  assign bus.a_sign    = aSign_q;
  assign bus.b_sign    = bSign_q;
  assign bus.a_exp     = aExp_q;
  assign bus.b_exp     = bExp_q;
  assign bus.a_man     = aMan_q;
  assign bus.b_man     = bMan_q;
  assign bus.a_class   = aClass_q;
  assign bus.b_class   = bClass_q;
  assign bus.unary_out = unaryOut_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Directed bench for the operand sequencer: binary32 instance plus a
// half-precision instance sharing clock and reset.
module tb_fpu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state32;
  logic [1:0] state16;
  int         testsRun    = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  fpu_operand_sequencer_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fpu_operand_sequencer_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fpu_operand_sequencer #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus32.slave),
    .state_o (state32)
  );

  fpu_operand_sequencer #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus16.slave),
    .state_o (state16)
  );

  function automatic logic [36:0] aFields32();
    return {bus32.a_sign, bus32.a_exp, bus32.a_man, bus32.a_class};
  endfunction

  function automatic logic [36:0] bFields32();
    return {bus32.b_sign, bus32.b_exp, bus32.b_man, bus32.b_class};
  endfunction

  task automatic idleInputs();
    bus32.in_data   = '0;
    bus32.in_valid  = 1'b0;
    bus32.in_unary  = 1'b0;
    bus32.out_ready = 1'b0;
    bus16.in_data   = '0;
    bus16.in_valid  = 1'b0;
    bus16.in_unary  = 1'b0;
    bus16.out_ready = 1'b0;
  endtask

  // Called on a falling edge with the DUT in GET_A; returns on the falling
  // edge where the pair is being presented in PUT.
  task automatic drivePair32(input logic [31:0] a, input logic [31:0] b, input logic unary);
    bus32.in_data  = a;
    bus32.in_unary = unary;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    if (!unary) begin
      bus32.in_data  = b;
      bus32.in_unary = 1'b0;
      @(negedge clk);
    end
    bus32.in_valid = 1'b0;
    bus32.in_unary = 1'b0;
    @(negedge clk);
  endtask

  task automatic drainPut32();
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    testsRun++;
    if ({state32, bus32.in_ready, bus32.out_valid, bus32.unary_out} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b",
               {state32, bus32.in_ready, bus32.out_valid, bus32.unary_out}, 5'b00100);
    end
    testsRun++;
    if ({aFields32(), bFields32()} !== 74'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_fields: got %h expected 0", {aFields32(), bFields32()});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_binary32();
    bus32.in_data  = 32'h3F80_0000;
    bus32.in_valid = 1'b1;
    testsRun++;
    if ({state32, bus32.in_ready} !== {2'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL bin_get_a: got %b expected %b", {state32, bus32.in_ready}, 3'b001);
    end
    @(negedge clk);
    testsRun++;
    if ({state32, bus32.in_ready} !== {2'd1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL bin_get_b: got %b expected %b", {state32, bus32.in_ready}, 3'b011);
    end
    bus32.in_data = 32'h4000_0000;
    @(negedge clk);
    testsRun++;
    if ({state32, bus32.in_ready, bus32.out_valid} !== {2'd2, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL bin_unpack: got %b expected %b",
               {state32, bus32.in_ready, bus32.out_valid}, 4'b1000);
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({state32, bus32.out_valid, bus32.unary_out} !== {2'd3, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL bin_put: got %b expected %b",
               {state32, bus32.out_valid, bus32.unary_out}, 4'b1110);
    end
    testsRun++;
    if (aFields32() !== {1'b0, 8'd127, 24'h80_0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL bin_a_fields: got %h expected %h", aFields32(),
               {1'b0, 8'd127, 24'h80_0000, 4'b0000});
    end
    testsRun++;
    if (bFields32() !== {1'b0, 8'd128, 24'h80_0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL bin_b_fields: got %h expected %h", bFields32(),
               {1'b0, 8'd128, 24'h80_0000, 4'b0000});
    end
    @(negedge clk);
    bus32.out_ready = 1'b0;
    testsRun++;
    if ({state32, bus32.out_valid} !== {2'd0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL bin_return: got %b expected %b", {state32, bus32.out_valid}, 3'b000);
    end
  endtask

  task automatic test_specials();
    drivePair32(32'h7F80_0000, 32'hFFC0_0001, 1'b0);
    testsRun++;
    if (aFields32() !== {1'b0, 8'd255, 24'h80_0000, 4'b0100}) begin
      testsFailed++;
      $display("[TB] FAIL spec_inf: got %h expected %h", aFields32(),
               {1'b0, 8'd255, 24'h80_0000, 4'b0100});
    end
    testsRun++;
    if (bFields32() !== {1'b1, 8'd255, 24'hC0_0001, 4'b1000}) begin
      testsFailed++;
      $display("[TB] FAIL spec_nan: got %h expected %h", bFields32(),
               {1'b1, 8'd255, 24'hC0_0001, 4'b1000});
    end
    drainPut32();
    drivePair32(32'h0000_0001, 32'h8000_0000, 1'b0);
    testsRun++;
    if (aFields32() !== {1'b0, 8'd1, 24'h00_0001, 4'b0010}) begin
      testsFailed++;
      $display("[TB] FAIL spec_denorm: got %h expected %h", aFields32(),
               {1'b0, 8'd1, 24'h00_0001, 4'b0010});
    end
    testsRun++;
    if (bFields32() !== {1'b1, 8'd0, 24'h00_0000, 4'b0001}) begin
      testsFailed++;
      $display("[TB] FAIL spec_negzero: got %h expected %h", bFields32(),
               {1'b1, 8'd0, 24'h00_0000, 4'b0001});
    end
    drainPut32();
  endtask

  task automatic test_backpressure();
    drivePair32(32'h3F80_0000, 32'h4000_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_data  = 32'hDEAD_BEE0 + 32'(i);
      bus32.in_unary = 1'(i);
      @(negedge clk);
      testsRun++;
      if ({state32, bus32.in_ready, bus32.out_valid} !== {2'd3, 1'b0, 1'b1}) begin
        testsFailed++;
        $display("[TB] FAIL bp_ctrl[%0d]: got %b expected %b", i,
                 {state32, bus32.in_ready, bus32.out_valid}, 4'b1101);
      end
      testsRun++;
      if ({aFields32(), bFields32()} !== {1'b0, 8'd127, 24'h80_0000, 4'b0000,
                                          1'b0, 8'd128, 24'h80_0000, 4'b0000}) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold[%0d]: got %h", i, {aFields32(), bFields32()});
      end
    end
    bus32.in_valid = 1'b0;
    bus32.in_unary = 1'b0;
    drainPut32();
    @(negedge clk);
    testsRun++;
    if ({state32, bus32.in_ready} !== {2'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got %b expected %b", {state32, bus32.in_ready}, 3'b001);
    end
  endtask

  task automatic test_unary();
    bus32.in_data  = 32'h4049_0FDB;
    bus32.in_unary = 1'b1;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.in_unary = 1'b0;
    testsRun++;
    if (state32 !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL unary_skip_b: got %0d expected 2", state32);
    end
    @(negedge clk);
    testsRun++;
    if ({state32, bus32.out_valid, bus32.unary_out} !== {2'd3, 1'b1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL unary_put: got %b expected %b",
               {state32, bus32.out_valid, bus32.unary_out}, 4'b1111);
    end
    testsRun++;
    if (aFields32() !== {1'b0, 8'd128, 24'hC9_0FDB, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL unary_a: got %h expected %h", aFields32(),
               {1'b0, 8'd128, 24'hC9_0FDB, 4'b0000});
    end
    testsRun++;
    if (bFields32() !== {1'b0, 8'd0, 24'h00_0000, 4'b0001}) begin
      testsFailed++;
      $display("[TB] FAIL unary_b_forced: got %h expected %h", bFields32(),
               {1'b0, 8'd0, 24'h00_0000, 4'b0001});
    end
    drainPut32();
    drivePair32(32'h3F80_0000, 32'h4000_0000, 1'b0);
    testsRun++;
    if ({bus32.unary_out, bFields32()} !== {1'b0, 1'b0, 8'd128, 24'h80_0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL unary_cleared: got %h expected %h", {bus32.unary_out, bFields32()},
               {1'b0, 1'b0, 8'd128, 24'h80_0000, 4'b0000});
    end
    drainPut32();
  endtask

  task automatic test_reset_midop();
    bus32.in_data  = 32'h3F80_0000;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    testsRun++;
    if (state32 !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL midop_in_get_b: got %0d expected 1", state32);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({state32, bus32.out_valid, bus32.in_ready, bus32.unary_out} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL midop_async_ctrl: got %b expected %b",
               {state32, bus32.out_valid, bus32.in_ready, bus32.unary_out}, 5'b00010);
    end
    testsRun++;
    if ({aFields32(), bFields32()} !== 74'd0) begin
      testsFailed++;
      $display("[TB] FAIL midop_async_fields: got %h expected 0", {aFields32(), bFields32()});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (state32 !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL midop_after_reset: got %0d expected 0", state32);
    end
    drivePair32(32'hC000_0000, 32'h3F80_0000, 1'b0);
    testsRun++;
    if ({aFields32(), bFields32()} !== {1'b1, 8'd128, 24'h80_0000, 4'b0000,
                                        1'b0, 8'd127, 24'h80_0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL midop_next_pair: got %h", {aFields32(), bFields32()});
    end
    drainPut32();
  endtask

  task automatic test_half();
    bus16.in_data  = 16'h3C00;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_data = 16'h7C00;
    @(negedge clk);
    bus16.in_valid  = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({state16, bus16.out_valid} !== {2'd3, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL half_put: got %b expected %b", {state16, bus16.out_valid}, 3'b111);
    end
    testsRun++;
    if ({bus16.a_sign, bus16.a_exp, bus16.a_man, bus16.a_class} !== {1'b0, 5'd15, 11'h400, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL half_a: got %h expected %h",
               {bus16.a_sign, bus16.a_exp, bus16.a_man, bus16.a_class},
               {1'b0, 5'd15, 11'h400, 4'b0000});
    end
    testsRun++;
    if ({bus16.b_sign, bus16.b_exp, bus16.b_man, bus16.b_class} !== {1'b0, 5'd31, 11'h400, 4'b0100}) begin
      testsFailed++;
      $display("[TB] FAIL half_b_inf: got %h expected %h",
               {bus16.b_sign, bus16.b_exp, bus16.b_man, bus16.b_class},
               {1'b0, 5'd31, 11'h400, 4'b0100});
    end
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    testsRun++;
    if (state16 !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL half_return: got %0d expected 0", state16);
    end
  endtask

  initial begin
    test_reset();
    test_binary32();
    test_specials();
    test_backpressure();
    test_unary();
    test_reset_midop();
    test_half();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fpu_operand_sequencer.md
Name: fpu_operand_sequencer

Overview:
Parametrised successor to the FPU front-end state sequencer. It captures operand A and then operand B from a shared valid/ready input stream, and unpacks each operand into sign, exponent, mantissa (hidden bit restored) and a special-value class. It then presents the pair on a valid/ready output stream to the downstream FPU datapath. It adds a unary mode that skips operand B, plus format generalisation through exponent and mantissa widths.

Parameters:
EXP_W, 8, exponent field width in bits.
MAN_W, 23, stored mantissa field width in bits (fraction without hidden bit).

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  reset, asynchronous, active-high.
in_data  in  1+EXP_W+MAN_W  packed IEEE-style operand {sign, exp, man}.
in_valid  in  1  in_data valid.
in_unary  in  1  sampled only with operand A; 1 = no operand B for this operation.
in_ready  out  1  sequencer can accept an operand this cycle.
out_valid  out  1  unpacked operand pair valid.
out_ready  in  1  downstream accepts pair.
a_sign, b_sign  out  1  operand sign.
a_exp, b_exp  out  EXP_W  biased exponent (denormals reported as 1).
a_man, b_man  out  MAN_W+1  mantissa with hidden bit at MSB.
a_class, b_class  out  4  one-hot {nan, inf, denorm, zero}; 0000 = normal.
unary_out  out  1  pair belongs to a unary operation.
state_out  out  2  current state encoding, for debug.

Behaviour:
- States (2-bit encoding): GET_A=0, GET_B=1, UNPACK=2, PUT=3.
- Reset (async, rst=1):
  - state=GET_A immediately.
  - All registered outputs and captured operands clear to 0, including out_valid=0 and unary_out=0.
- in_ready is decoded from state: 1 in GET_A and GET_B, 0 otherwise. It reads 1 while rst is held.
- out_valid is decoded from state: 1 only in PUT.
- GET_A:
  - On in_valid&&in_ready: capture in_data as raw A and latch unary=in_unary.
  - Next state is UNPACK if in_unary=1, else GET_B.
  - Without in_valid: hold.
- GET_B:
  - On in_valid: capture raw B, go to UNPACK.
  - in_unary is ignored here.
- UNPACK:
  - Exactly one cycle, unconditional.
  - Registers unpacked fields for A and B and unary_out; next state is PUT.
- PUT:
  - Outputs are held stable and in_data/in_valid are ignored.
  - On out_ready: go to GET_A.
  - No same-cycle acceptance of the next A; the earliest next accept is the cycle after the handshake.
- Latency: the B accept edge (or the A accept edge in unary mode) is followed by out_valid=1 after the next rising edge, i.e. 2 edges after accept. Minimum throughput is one pair per 4 cycles (3 cycles in unary mode).
- Unpack rules per operand, with e = exp field and m = man field:
  - e=0, m=0: zero. exp=0, man=0, class=0001.
  - e=0, m≠0: denorm. exp=1, man={0,m}, class=0010.
  - e=all ones, m=0: inf. exp=e, man={1,m}, class=0100.
  - e=all ones, m≠0: nan. exp=e, man={1,m}, class=1000.
  - Otherwise normal. exp=e, man={1,m}, class=0000.
  - Sign is passed through in all cases, including for zero and nan.
- Unary mode: B outputs are forced to sign=0, exp=0, man=0, class=0001, and unary_out=1.
- Reset mid-operation from any state: partially captured operands are discarded, and out_valid drops asynchronously.

Decomposition:
- Shared package fpu_pkg holds:
  - state encodings GET_A/GET_B/UNPACK/PUT;
  - class bit indices CLS_ZERO=0, CLS_DENORM=1, CLS_INF=2, CLS_NAN=3;
  - a function or localparam deriving W=1+EXP_W+MAN_W.
- One sub-module: fpu_unpack, purely combinational, parametrised by EXP_W and MAN_W. It is instantiated twice (A and B) and its outputs are registered in UNPACK.

Test Plan:
- Binary32: A=0x3F800000, B=0x40000000, out_ready=1. Expect a_exp=127, a_man=0x800000, b_exp=128, b_man=0x800000, both class=0000. out_valid rises 2 edges after B accept, and state_out follows 0→1→2→3→0.
- Specials: A=0x7F800000, B=0xFFC00001. Expect a_class=0100, b_class=1000, b_sign=1. Then A=0x00000001, B=0x80000000: expect a_exp=1, a_man=0x000001, a_class=0010, b_class=0001, b_sign=1.
- Backpressure: hold out_ready=0 for 5 cycles in PUT while driving in_valid=1 with new data. Expect outputs unchanged, in_ready=0, no capture. out_ready=1 returns state to GET_A.
- Unary: A=0x40490FDB with in_unary=1. Expect GET_B skipped (state 0→2→3), a_exp=128, a_man=0xC90FDB, b class=0001, unary_out=1. The next operation with in_unary=0 shows unary_out=0.
- Reset mid-op: accept A, then pulse rst between clock edges while in GET_B. Expect state_out=0 and all outputs 0 before the next edge; the following A/B pair unpacks correctly.
- EXP_W=5, MAN_W=10 instance: A=0x3C00, B=0x7C00. Expect a_exp=15, a_man=0x400, b_class=0100.
